// File: rtl/mult_arbiter_if.sv
// rtl/mult_arbiter_if.sv - requester, result and shared-multiplier signals of the arbiter
interface mult_arbiter_if;
  // requester 0
  logic       req0;
  logic [3:0] a0;
  logic [3:0] b0;
  // requester 1
  logic       req1;
  logic [3:0] a1;
  logic [3:0] b1;
  // completion and result
  logic       ack0;
  logic       ack1;
  logic [7:0] dout;
  logic       dout_id;
  logic       busy;
  // shared multiplier
  logic       mul_start;
  logic [3:0] mul_din0;
  logic [3:0] mul_din1;
  logic [7:0] mul_dout;

  // system side: requesters plus the multiplier that returns mul_dout
  modport master (
    output req0, a0, b0, req1, a1, b1, mul_dout,
    input  ack0, ack1, dout, dout_id, busy, mul_start, mul_din0, mul_din1
  );

  // arbiter side
  modport slave (
    input  req0, a0, b0, req1, a1, b1, mul_dout,
    output ack0, ack1, dout, dout_id, busy, mul_start, mul_din0, mul_din1
  );
endinterface

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter sharing one 4x4 multiplier between two requesters
module mult_arbiter (
  input  logic          clk,
  input  logic          rst,
  mult_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPER = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;

  // operands and owner of the in-flight operation, frozen at the grant edge
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       op_id;

  // round-robin pointer; reset to 1 so the first tie goes to requester 0
  logic       last_served;

  logic [7:0] dout_q;
  logic       dout_id_q;

  logic       any_req;
  logic       grant_id;
  logic       grant;

  // winner selection: a lone request wins, a tie goes to whoever was not served last
  always_comb begin
    any_req  = bus.req0 | bus.req1;
    grant_id = 1'b0;
    if (bus.req0 && bus.req1) begin
      grant_id = ~last_served;
    end else if (bus.req1) begin
      grant_id = 1'b1;
    end
    grant = (state == IDLE) && any_req;
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state: a grant runs a fixed four-cycle sequence regardless of inputs
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = any_req ? OPER : IDLE;
      OPER:    state_nxt = CAPT;
      CAPT:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // latch the winner's operands and id; later input changes are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a  <= 4'd0;
      op_b  <= 4'd0;
      op_id <= 1'b0;
    end else if (grant) begin
      op_a  <= grant_id ? bus.a1 : bus.a0;
      op_b  <= grant_id ? bus.b1 : bus.b0;
      op_id <= grant_id;
    end
  end

  // capture the multiplier result while in CAPT; held until the next capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q    <= 8'd0;
      dout_id_q <= 1'b0;
    end else if (state == CAPT) begin
      dout_q    <= bus.mul_dout;
      dout_id_q <= op_id;
    end
  end

  // advance the round-robin pointer only when an operation actually completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_served <= 1'b1;
    end else if (state == DONE) begin
      last_served <= op_id;
    end
  end

  // outputs decoded from state; the reset path clears them without a clock
  assign bus.busy      = (state != IDLE);
  assign bus.mul_start = (state == OPER) || (state == CAPT);
  assign bus.mul_din0  = op_a;
  assign bus.mul_din1  = op_b;
  assign bus.ack0      = (state == DONE) && !op_id;
  assign bus.ack1      = (state == DONE) && op_id;
  assign bus.dout      = dout_q;
  assign bus.dout_id   = dout_id_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - directed and randomized checks of mult_arbiter against a reference model
module tb_mult_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mult_arbiter_if bus ();

  mult_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // shared multiplier: combinational while started, holds its last product otherwise
  logic [7:0] held_prod = 8'd0;
  always @(posedge clk) begin
    if (bus.mul_start) held_prod <= {4'd0, bus.mul_din0} * {4'd0, bus.mul_din1};
  end
  assign bus.mul_dout = bus.mul_start ? ({4'd0, bus.mul_din0} * {4'd0, bus.mul_din1}) : held_prod;

  int total  = 0;
  int passed = 0;

  // reference state: who was served last, and the product the arbiter should hold
  int last_ref = 1;
  int dout_ref = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input bit r0, input bit r1, input int x0, input int y0,
                            input int x1, input int y1);
    bus.req0 = r0;
    bus.req1 = r1;
    bus.a0   = 4'(x0);
    bus.b0   = 4'(y0);
    bus.a1   = 4'(x1);
    bus.b1   = 4'(y1);
  endtask

  // one full operation from IDLE; perturb scrambles inputs in flight, drop releases the requests
  task automatic run_op(input bit r0, input bit r1, input int x0, input int y0,
                        input int x1, input int y1, input bit perturb, input bit drop);
    int w;
    int p;
    w = (r0 && r1) ? (1 - last_ref) : (r1 ? 1 : 0);
    p = (w == 1) ? x1 * y1 : x0 * y0;
    set_inputs(r0, r1, x0, y0, x1, y1);
    tick();
    chk("oper_busy", int'(bus.busy), 1);
    chk("oper_start", int'(bus.mul_start), 1);
    chk("oper_din0", int'(bus.mul_din0), (w == 1) ? x1 : x0);
    chk("oper_din1", int'(bus.mul_din1), (w == 1) ? y1 : y0);
    if (perturb) begin
      bus.a0   = 4'd9;
      bus.b0   = 4'($urandom);
      bus.a1   = 4'($urandom);
      bus.b1   = 4'($urandom);
      bus.req1 = 1'($urandom);
    end
    if (drop) begin
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
    end
    tick();
    chk("capt_start", int'(bus.mul_start), 1);
    chk("capt_ack", int'(bus.ack0 | bus.ack1), 0);
    tick();
    chk("done_ack0", int'(bus.ack0), (w == 0) ? 1 : 0);
    chk("done_ack1", int'(bus.ack1), (w == 1) ? 1 : 0);
    chk("done_dout", int'(bus.dout), p);
    chk("done_id", int'(bus.dout_id), w);
    chk("done_start", int'(bus.mul_start), 0);
    last_ref = w;
    dout_ref = p;
    tick();
    chk("idle_busy", int'(bus.busy), 0);
    chk("idle_ack", int'(bus.ack0 | bus.ack1), 0);
    chk("idle_dout", int'(bus.dout), dout_ref);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack0"}, int'(bus.ack0), 0);
    chk({tag, "_ack1"}, int'(bus.ack1), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_start"}, int'(bus.mul_start), 0);
    chk({tag, "_din0"}, int'(bus.mul_din0), 0);
    chk({tag, "_din1"}, int'(bus.mul_din1), 0);
    chk({tag, "_dout"}, int'(bus.dout), 0);
    chk({tag, "_id"}, int'(bus.dout_id), 0);
  endtask

  initial begin
    set_inputs(0, 0, 0, 0, 0, 0);

    // asynchronous reset takes effect before any clock edge
    #1 rst = 1'b1;
    #2;
    chk_reset_outputs("rst");
    tick();
    tick();
    rst = 1'b0;
    last_ref = 1;
    dout_ref = 0;

    // first tie after reset goes to requester 0, then alternation
    run_op(1, 1, 2, 3, 4, 4, 0, 0);
    run_op(1, 1, 2, 3, 4, 4, 0, 0);
    run_op(1, 1, 2, 3, 4, 4, 0, 0);

    // single requesters, including the largest product
    run_op(1, 0, 3, 5, 0, 0, 0, 0);
    run_op(0, 1, 0, 0, 15, 15, 0, 0);

    // operands and req1 change during the operation
    run_op(1, 0, 3, 5, 1, 1, 1, 0);

    // requests released mid-operation: ack still comes, no retry afterwards
    run_op(0, 1, 7, 7, 6, 9, 0, 1);
    set_inputs(0, 0, 0, 0, 0, 0);
    tick();
    chk("noretry_busy", int'(bus.busy), 0);

    // long idle holds the last product
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_busy_long", int'(bus.busy), 0);
      chk("idle_start_long", int'(bus.mul_start), 0);
      chk("idle_dout_long", int'(bus.dout), dout_ref);
    end

    // reset during CAPT aborts without an ack
    set_inputs(1, 1, 5, 5, 6, 6);
    tick();
    tick();
    chk("pre_rst_start", int'(bus.mul_start), 1);
    #1 rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    set_inputs(0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    last_ref = 1;
    dout_ref = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_ack", int'(bus.ack0 | bus.ack1), 0);
      chk("post_rst_busy", int'(bus.busy), 0);
    end
    run_op(1, 1, 2, 7, 3, 3, 0, 0);

    // randomized traffic
    for (int i = 0; i < 30; i++) begin
      int sel;
      sel = int'($urandom_range(0, 2));
      run_op((sel != 1), (sel != 0),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
